// File: rtl/mips_mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter.
// Opcode constants and FSM state encoding.
package mips_mem_arbiter_pkg;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Bundle of both requester ports and the data-memory drive.
// slave = arbiter side, master = requesters plus memory.
interface mips_mem_arbiter_if;

    logic        p0_req;
    logic        p0_we;
    logic [5:0]  p0_op;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_ack;
    logic        p0_err;
    logic [31:0] p0_rdata;

    logic        p1_req;
    logic        p1_we;
    logic [5:0]  p1_op;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_ack;
    logic        p1_err;
    logic [31:0] p1_rdata;

    logic [31:0] mem_address;
    logic [31:0] write_data;
    logic [5:0]  opCode;
    logic        sig_mem_read;
    logic        sig_mem_write;
    logic [31:0] read_data;

    modport slave (
        input  p0_req, p0_we, p0_op, p0_addr, p0_wdata,
        output p0_ack, p0_err, p0_rdata,
        input  p1_req, p1_we, p1_op, p1_addr, p1_wdata,
        output p1_ack, p1_err, p1_rdata,
        output mem_address, write_data, opCode,
        output sig_mem_read, sig_mem_write,
        input  read_data
    );

    modport master (
        output p0_req, p0_we, p0_op, p0_addr, p0_wdata,
        input  p0_ack, p0_err, p0_rdata,
        output p1_req, p1_we, p1_op, p1_addr, p1_wdata,
        input  p1_ack, p1_err, p1_rdata,
        input  mem_address, write_data, opCode,
        input  sig_mem_read, sig_mem_write,
        output read_data
    );

endinterface

// File: rtl/mips_rr_arb2.sv
// Two-way round-robin selector.
// last = index of the port granted most recently.
module mips_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory.
// Each access walks IDLE -> ACCESS -> RESP, one strobe, one ack.
module mips_mem_arbiter
    import mips_mem_arbiter_pkg::*;
#(
    parameter int MEM_DEPTH = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    mips_mem_arbiter_if.slave  bus
);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  grant;
    logic        any_req;
    logic        last_q;
    logic        owner_q;
    logic        we_q;
    logic        err_q;
    logic [5:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        sel_we;
    logic [5:0]  sel_op;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_bad;
    logic        rd_ok;

    assign any_req = bus.p0_req | bus.p1_req;

    mips_rr_arb2 u_rr (
        .req   ({bus.p1_req, bus.p0_req}),
        .last  (last_q),
        .grant (grant)
    );

    assign sel_we    = grant[1] ? bus.p1_we    : bus.p0_we;
    assign sel_op    = grant[1] ? bus.p1_op    : bus.p0_op;
    assign sel_addr  = grant[1] ? bus.p1_addr  : bus.p0_addr;
    assign sel_wdata = grant[1] ? bus.p1_wdata : bus.p0_wdata;

    // Illegal store opcode or out-of-range word: skip memory, flag error.
    assign sel_bad = (sel_we && !is_store(sel_op)) ||
                     (sel_addr >= 32'(MEM_DEPTH));

    assign rd_ok = !we_q && !err_q;

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: fixed three-step walk once a request is taken.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = any_req ? ACCESS : IDLE;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the winner's request and rotate priority on each grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && any_req) begin
            last_q  <= grant[1];
            owner_q <= grant[1];
            we_q    <= sel_we;
            err_q   <= sel_bad;
            op_q    <= sel_op;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
    end

    assign bus.mem_address = addr_q;
    assign bus.write_data  = wdata_q;
    assign bus.opCode      = op_q;

    // Strobes in ACCESS only; ack, err and read data in RESP to the owner.
    always_comb begin
        bus.sig_mem_read  = 1'b0;
        bus.sig_mem_write = 1'b0;
        bus.p0_ack        = 1'b0;
        bus.p0_err        = 1'b0;
        bus.p0_rdata      = '0;
        bus.p1_ack        = 1'b0;
        bus.p1_err        = 1'b0;
        bus.p1_rdata      = '0;
        unique case (state)
            ACCESS: begin
                bus.sig_mem_read  = !err_q && !we_q;
                bus.sig_mem_write = !err_q && we_q;
            end
            RESP: begin
                if (owner_q) begin
                    bus.p1_ack   = 1'b1;
                    bus.p1_err   = err_q;
                    bus.p1_rdata = rd_ok ? bus.read_data : '0;
                end else begin
                    bus.p0_ack   = 1'b1;
                    bus.p0_err   = err_q;
                    bus.p0_rdata = rd_ok ? bus.read_data : '0;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter.
// Word-addressed memory model with SB/SH/SW lanes on the low bits.
module tb_mips_mem_arbiter;
    import mips_mem_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    logic [31:0] mem [0:255];

    mips_mem_arbiter_if bus ();

    mips_mem_arbiter #(.MEM_DEPTH(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: write lane chosen by opcode, read data one cycle late.
    always @(posedge clk) begin
        if (bus.sig_mem_write) begin
            case (bus.opCode)
                OP_SB:   mem[bus.mem_address[7:0]][7:0]  <= bus.write_data[7:0];
                OP_SH:   mem[bus.mem_address[7:0]][15:0] <= bus.write_data[15:0];
                default: mem[bus.mem_address[7:0]]       <= bus.write_data;
            endcase
        end
        if (bus.sig_mem_read) begin
            bus.read_data <= mem[bus.mem_address[7:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit p, input bit req, input bit we,
                         input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata);
        if (p) begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_op = op;
            bus.p1_addr = addr; bus.p1_wdata = wdata;
        end else begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_op = op;
            bus.p0_addr = addr; bus.p0_wdata = wdata;
        end
    endtask

    // One access from IDLE: strobe in cycle 2, ack in cycle 3.
    task automatic xfer(input string tag, input bit p, input bit we,
                        input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] exp_stb,
                        input logic exp_err, input logic [31:0] exp_rd);
        @(negedge clk);
        drive(p, 1'b1, we, op, addr, wdata);
        @(negedge clk);
        check({tag, "/stb"}, 32'({bus.sig_mem_write, bus.sig_mem_read}),
              32'(exp_stb));
        check({tag, "/op"}, 32'(bus.opCode), 32'(op));
        check({tag, "/addr"}, bus.mem_address, addr);
        if (exp_stb[1]) check({tag, "/wd"}, bus.write_data, wdata);
        check({tag, "/ack_early"}, 32'({bus.p1_ack, bus.p0_ack}), 32'd0);
        @(negedge clk);
        check({tag, "/ack"}, 32'({bus.p1_ack, bus.p0_ack}),
              p ? 32'd2 : 32'd1);
        check({tag, "/err"}, 32'(p ? bus.p1_err : bus.p0_err),
              32'(exp_err));
        check({tag, "/rdata"}, p ? bus.p1_rdata : bus.p0_rdata, exp_rd);
        check({tag, "/stb_resp"},
              32'({bus.sig_mem_write, bus.sig_mem_read}), 32'd0);
        drive(p, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] exp_ack;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);

        #3;
        check("rst/ack", 32'({bus.p1_ack, bus.p0_ack}), 32'd0);
        check("rst/err", 32'({bus.p1_err, bus.p0_err}), 32'd0);
        check("rst/stb", 32'({bus.sig_mem_write, bus.sig_mem_read}), 32'd0);
        check("rst/maddr", bus.mem_address, 32'd0);
        check("rst/wdata", bus.write_data, 32'd0);
        check("rst/opcode", 32'(bus.opCode), 32'd0);
        check("rst/rdata0", bus.p0_rdata, 32'd0);
        check("rst/rdata1", bus.p1_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        xfer("sw5", 1'b0, 1'b1, OP_SW, 32'd5, 32'hDEADBEEF,
             2'b10, 1'b0, 32'd0);
        xfer("lw5", 1'b0, 1'b0, OP_LW, 32'd5, 32'd0,
             2'b01, 1'b0, 32'hDEADBEEF);

        xfer("sw7", 1'b1, 1'b1, OP_SW, 32'd7, 32'h11223344,
             2'b10, 1'b0, 32'd0);
        xfer("sb7", 1'b1, 1'b1, OP_SB, 32'd7, 32'h000000A5,
             2'b10, 1'b0, 32'd0);
        xfer("lw7a", 1'b0, 1'b0, OP_LW, 32'd7, 32'd0,
             2'b01, 1'b0, 32'h112233A5);
        xfer("sh7", 1'b1, 1'b1, OP_SH, 32'd7, 32'h0000BEEF,
             2'b10, 1'b0, 32'd0);
        xfer("lw7b", 1'b1, 1'b0, 6'b100000, 32'd7, 32'd0,
             2'b01, 1'b0, 32'h1122BEEF);

        xfer("badop", 1'b0, 1'b1, 6'b100011, 32'd3, 32'h55,
             2'b00, 1'b1, 32'd0);
        xfer("rd300", 1'b1, 1'b0, OP_LW, 32'd300, 32'd0,
             2'b00, 1'b1, 32'd0);
        xfer("sw256", 1'b0, 1'b1, OP_SW, 32'd256, 32'h77,
             2'b00, 1'b1, 32'd0);
        xfer("sw255", 1'b1, 1'b1, OP_SW, 32'd255, 32'hCAFEF00D,
             2'b10, 1'b0, 32'd0);
        xfer("lw255", 1'b0, 1'b0, OP_LW, 32'd255, 32'd0,
             2'b01, 1'b0, 32'hCAFEF00D);

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, OP_LW, 32'd5, 32'd0);
        drive(1'b1, 1'b1, 1'b0, OP_LW, 32'd7, 32'd0);
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            exp_ack = (i == 2 || i == 8) ? 2'b01 :
                      (i == 5 || i == 11) ? 2'b10 : 2'b00;
            check($sformatf("rr%0d/ack", i),
                  32'({bus.p1_ack, bus.p0_ack}), 32'(exp_ack));
            check($sformatf("rr%0d/rd0", i), bus.p0_rdata,
                  exp_ack[0] ? 32'hDEADBEEF : 32'd0);
            check($sformatf("rr%0d/rd1", i), bus.p1_rdata,
                  exp_ack[1] ? 32'h1122BEEF : 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
        @(negedge clk);
        check("rr/idle", 32'({bus.p1_ack, bus.p0_ack,
              bus.sig_mem_write, bus.sig_mem_read}), 32'd0);

        xfer("sw9a", 1'b0, 1'b1, OP_SW, 32'd9, 32'hAAAA5555,
             2'b10, 1'b0, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, OP_SW, 32'd9, 32'h12345678);
        @(negedge clk);
        check("rstacc/stb", 32'(bus.sig_mem_write), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstacc/stb_drop",
              32'({bus.sig_mem_write, bus.sig_mem_read}), 32'd0);
        check("rstacc/maddr", bus.mem_address, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
        @(negedge clk);
        check("rstacc/noack", 32'({bus.p1_ack, bus.p0_ack}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstacc/idle", 32'({bus.p1_ack, bus.p0_ack,
              bus.sig_mem_write, bus.sig_mem_read}), 32'd0);
        xfer("lw9old", 1'b0, 1'b0, OP_LW, 32'd9, 32'd0,
             2'b01, 1'b0, 32'hAAAA5555);
        xfer("sw9re", 1'b0, 1'b1, OP_SW, 32'd9, 32'h12345678,
             2'b10, 1'b0, 32'd0);
        xfer("lw9new", 1'b0, 1'b0, OP_LW, 32'd9, 32'd0,
             2'b01, 1'b0, 32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
